// File: rtl/useq_control_pkg.sv
// Shared constants for the microcode control unit: word field layout helpers and bus index names.
package useq_control_pkg;

   localparam int unsigned OP_W_DEF  = 8;
   localparam int unsigned TS_W_DEF  = 3;
   localparam int unsigned SEL_W_DEF = 3;
   localparam int unsigned ALU_W_DEF = 6;

   // Fixed low part of the word: spare bits, then the four jump strobes, then bus_in select.
   localparam int unsigned SPARE_W = 2;
   localparam int unsigned JMP_W   = 4;
   localparam int unsigned JMP_LSB = SPARE_W;
   localparam int unsigned BIN_LSB = JMP_LSB + JMP_W;

   localparam int unsigned DEV_IDX = 6;

   typedef enum logic [2:0] {
      SRC_PC  = 3'd0,
      SRC_IOH = 3'd1,
      SRC_IOL = 3'd2,
      SRC_RAM = 3'd3,
      SRC_X   = 3'd4,
      SRC_Y   = 3'd5,
      SRC_DEV = 3'd6
   } src_sel_e;

   typedef enum logic [2:0] {
      SNK_NONE = 3'd0,
      SNK_MAR  = 3'd1,
      SNK_IR   = 3'd2,
      SNK_RAM  = 3'd3,
      SNK_X    = 3'd4,
      SNK_Y    = 3'd5,
      SNK_DEV  = 3'd6
   } snk_sel_e;

   function automatic int unsigned ui_width(input int unsigned sel_w, input int unsigned alu_w);
      return 1 + alu_w + sel_w + JMP_W + SPARE_W;
   endfunction

   function automatic int unsigned ovl_lsb(input int unsigned sel_w);
      return BIN_LSB + sel_w;
   endfunction

endpackage

// File: rtl/useq_control_if.sv
// IR/ROM/datapath-facing signal bundle of the microcode control unit.
interface useq_control_if
   import useq_control_pkg::*;
#(
   parameter int unsigned OP_W  = OP_W_DEF,
   parameter int unsigned TS_W  = TS_W_DEF,
   parameter int unsigned SEL_W = SEL_W_DEF,
   parameter int unsigned ALU_W = ALU_W_DEF
) ();
   localparam int unsigned UI_W  = ui_width(SEL_W, ALU_W);
   localparam int unsigned N_SEL = 1 << SEL_W;

   logic [OP_W-1:0]      opcode;
   logic [UI_W-1:0]      uinstr;
   logic                 dev_rdy;
   logic [OP_W+TS_W-1:0] uaddr;
   logic                 eo;
   logic [ALU_W-1:0]     alu_flags;
   logic [N_SEL-1:0]     bus_out_en;
   logic [N_SEL-1:0]     bus_in_en;
   logic                 rt;
   logic                 pp;
   logic [JMP_W-1:0]     jmp;
   logic                 stall;
   logic                 ucode_err;

   modport master (
      output opcode, uinstr, dev_rdy,
      input  uaddr, eo, alu_flags, bus_out_en, bus_in_en, rt, pp, jmp, stall, ucode_err
   );

   modport slave (
      input  opcode, uinstr, dev_rdy,
      output uaddr, eo, alu_flags, bus_out_en, bus_in_en, rt, pp, jmp, stall, ucode_err
   );

endinterface

// File: rtl/useq_control_onehot_dec.sv
// Binary select to one-hot enable decoder.
module onehot_dec #(
   parameter int unsigned SEL_W = 3
) (
   input  logic [SEL_W-1:0]      sel,
   output logic [(1<<SEL_W)-1:0] en
);

   always_comb begin
      en      = '0;
      en[sel] = 1'b1;
   end

endmodule

// File: rtl/useq_control.sv
// Microcode control unit: T-state counter, ROM addressing, micro-instruction register and decode.
// Optional device wait-state support is enabled with `define USEQ_DEV_WAIT_EN.
module useq_control
   import useq_control_pkg::*;
#(
   parameter int unsigned OP_W  = OP_W_DEF,
   parameter int unsigned TS_W  = TS_W_DEF,
   parameter int unsigned SEL_W = SEL_W_DEF,
   parameter int unsigned ALU_W = ALU_W_DEF
) (
   input logic           clk,
   input logic           reset,
   useq_control_if.slave bus
);

   localparam int unsigned UI_W    = ui_width(SEL_W, ALU_W);
   localparam int unsigned N_SEL   = 1 << SEL_W;
   localparam int unsigned OVL_LSB = ovl_lsb(SEL_W);
   localparam int unsigned EO_BIT  = OVL_LSB + ALU_W;
   localparam int unsigned OUT_LSB = EO_BIT - SEL_W;
   localparam int unsigned RT_BIT  = OUT_LSB - 1;
   localparam int unsigned PP_BIT  = OUT_LSB - 2;
   localparam int unsigned TS_MAX  = (1 << TS_W) - 1;

   logic [UI_W-1:0] r_ureg;
   logic            r_valid;
   logic [TS_W-1:0] r_tstate;
   logic            r_ucode_err;

   logic             w_ovl_ok;
   logic             w_in_rt;
   logic             w_wrap;
   logic             w_stall;
   logic [N_SEL-1:0] w_out_dec;
   logic [N_SEL-1:0] w_in_dec;
   logic [N_SEL-1:0] w_out_en;
   logic [N_SEL-1:0] w_in_en_raw;
   logic             w_unused;

   onehot_dec #(.SEL_W(SEL_W)) u_out_dec (
      .sel (r_ureg[OUT_LSB +: SEL_W]),
      .en  (w_out_dec)
   );

   onehot_dec #(.SEL_W(SEL_W)) u_in_dec (
      .sel (r_ureg[BIN_LSB +: SEL_W]),
      .en  (w_in_dec)
   );

   // Overlay fields (source select, RT, P+) only mean something when the ALU is not driving.
   assign w_ovl_ok    = r_valid & ~r_ureg[EO_BIT];
   assign w_out_en    = w_ovl_ok ? w_out_dec : '0;
   assign w_in_en_raw = r_valid ? {w_in_dec[N_SEL-1:1], 1'b0} : '0;

   // RT is looked at in the word arriving from ROM so the next address is already {opcode,0}.
   assign w_in_rt = ~bus.uinstr[EO_BIT] & bus.uinstr[RT_BIT];
   assign w_wrap  = (r_tstate == TS_W'(TS_MAX)) & ~w_in_rt;

`ifdef USEQ_DEV_WAIT_EN
   assign w_stall  = (w_out_en[DEV_IDX] | w_in_en_raw[DEV_IDX]) & ~bus.dev_rdy;
   assign w_unused = ^{r_ureg[SPARE_W-1:0], w_in_dec[0]};
`else
   assign w_stall  = 1'b0;
   assign w_unused = ^{r_ureg[SPARE_W-1:0], w_in_dec[0], bus.dev_rdy};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ureg      <= '0;
         r_valid     <= 1'b0;
         r_tstate    <= '0;
         r_ucode_err <= 1'b0;
      end else if (!w_stall) begin
         r_ureg   <= bus.uinstr;
         r_valid  <= 1'b1;
         r_tstate <= w_in_rt ? '0 : r_tstate + TS_W'(1);
         if (w_wrap) begin
            r_ucode_err <= 1'b1;
         end
      end
   end

   // While waiting on the device the source stays on the bus but no sink/side effect fires.
   assign bus.uaddr      = {bus.opcode, r_tstate};
   assign bus.eo         = r_valid & r_ureg[EO_BIT];
   assign bus.alu_flags  = r_valid ? r_ureg[OVL_LSB +: ALU_W] : '0;
   assign bus.bus_out_en = w_out_en;
   assign bus.bus_in_en  = w_stall ? '0 : w_in_en_raw;
   assign bus.rt         = w_ovl_ok & r_ureg[RT_BIT];
   assign bus.pp         = w_ovl_ok & r_ureg[PP_BIT] & ~w_stall;
   assign bus.jmp        = (r_valid & ~w_stall) ? r_ureg[JMP_LSB +: JMP_W] : '0;
   assign bus.stall      = w_stall;
   assign bus.ucode_err  = r_ucode_err;

endmodule

// File: tb/tb_useq_control.sv
// Randomized bench for useq_control against a word-level reference model, plus directed spot checks.
module tb_useq_control;

   logic clk = 1'b0;
   logic reset;
   bit   chk_en = 1'b0;
   int   total = 0;
   int   bad   = 0;

   useq_control_if #(.OP_W(8), .TS_W(3), .SEL_W(3), .ALU_W(6)) u_if ();

   useq_control #(.OP_W(8), .TS_W(3), .SEL_W(3), .ALU_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   always #5 clk = ~clk;

   // Reference state: last accepted word, whether one has been accepted, T-state, error flag.
   logic [15:0] m_word  = 16'h0;
   bit          m_valid = 1'b0;
   int          m_t     = 0;
   bit          m_err   = 1'b0;
   bit          m_in_rt;

   function automatic bit f_ovl();
      return m_valid && !m_word[15];
   endfunction

   function automatic int f_out_sel();
      return (int'(m_word) >> 12) % 8;
   endfunction

   function automatic int f_in_sel();
      return (int'(m_word) >> 6) % 8;
   endfunction

   function automatic bit f_stall();
`ifdef USEQ_DEV_WAIT_EN
      return m_valid && ((f_ovl() && f_out_sel() == 6) || f_in_sel() == 6) && !u_if.dev_rdy;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_word  = 16'h0;
         m_valid = 1'b0;
         m_t     = 0;
         m_err   = 1'b0;
      end else if (!f_stall()) begin
         m_in_rt = !u_if.uinstr[15] && u_if.uinstr[11];
         if (!m_in_rt && m_t == 7) m_err = 1'b1;
         m_t     = m_in_rt ? 0 : (m_t + 1) % 8;
         m_word  = u_if.uinstr;
         m_valid = 1'b1;
      end
   end

   // Every cycle: all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("uaddr", 32'(u_if.uaddr), 32'(int'(u_if.opcode) * 8 + m_t));
         check("eo", 32'(u_if.eo), 32'(m_valid && m_word[15]));
         check("alu_flags", 32'(u_if.alu_flags), m_valid ? 32'((int'(m_word) >> 9) % 64) : 32'd0);
         check("bus_out_en", 32'(u_if.bus_out_en), f_ovl() ? 32'(1 << f_out_sel()) : 32'd0);
         check("bus_in_en", 32'(u_if.bus_in_en),
               (m_valid && !f_stall() && f_in_sel() != 0) ? 32'(1 << f_in_sel()) : 32'd0);
         check("rt", 32'(u_if.rt), 32'(f_ovl() && m_word[11]));
         check("pp", 32'(u_if.pp), 32'(f_ovl() && m_word[10] && !f_stall()));
         check("jmp", 32'(u_if.jmp),
               (m_valid && !f_stall()) ? 32'((int'(m_word) >> 2) % 16) : 32'd0);
         check("stall", 32'(u_if.stall), 32'(f_stall()));
         check("ucode_err", 32'(u_if.ucode_err), 32'(m_err));
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      reset         = 1'b1;
      u_if.opcode   = 8'h5A;
      u_if.uinstr   = 16'hFFFF;
      u_if.dev_rdy  = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      check("rst_eo", 32'(u_if.eo), 32'd0);
      check("rst_in_en", 32'(u_if.bus_in_en), 32'd0);
      check("rst_uaddr", 32'(u_if.uaddr), 32'h2D0);

      // First decode appears one cycle after release.
      reset = 1'b0;
      tick();
      check("ffff_eo", 32'(u_if.eo), 32'd1);
      check("ffff_alu", 32'(u_if.alu_flags), 32'h3F);
      check("ffff_in_en", 32'(u_if.bus_in_en), 32'h80);
      check("ffff_uaddr", 32'(u_if.uaddr), 32'h2D1);

      // XO -> MI with RT and P+.
      u_if.uinstr = 16'h4C40;
      tick();
      check("xo_out_en", 32'(u_if.bus_out_en), 32'h10);
      check("mi_in_en", 32'(u_if.bus_in_en), 32'h02);
      check("xo_rt", 32'(u_if.rt), 32'd1);
      check("xo_pp", 32'(u_if.pp), 32'd1);
      check("xo_uaddr", 32'(u_if.uaddr), 32'h2D0);

      // ALU drives bus with flags 2A.
      u_if.uinstr = 16'hD400;
      tick();
      check("alu_eo", 32'(u_if.eo), 32'd1);
      check("alu_flags2a", 32'(u_if.alu_flags), 32'h2A);
      check("alu_out_en", 32'(u_if.bus_out_en), 32'd0);
      check("alu_rt", 32'(u_if.rt), 32'd0);
      check("alu_uaddr", 32'(u_if.uaddr), 32'h2D1);

      // Eight words without RT wrap the T-state and set the sticky error.
      reset       = 1'b1;
      u_if.uinstr = 16'h0000;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("pre_wrap_err", 32'(u_if.ucode_err), 32'd0);
      check("pre_wrap_t", 32'(u_if.uaddr[2:0]), 32'd7);
      tick();
      check("wrap_err", 32'(u_if.ucode_err), 32'd1);
      check("wrap_t", 32'(u_if.uaddr[2:0]), 32'd0);
      u_if.uinstr = 16'h0800;
      tick();
      tick();
      check("err_sticky", 32'(u_if.ucode_err), 32'd1);

      // DO -> YI with the device not ready.
      u_if.opcode  = 8'h33;
      reset        = 1'b1;
      u_if.uinstr  = 16'h6140;
      u_if.dev_rdy = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      u_if.uinstr = 16'h0000;
`ifdef USEQ_DEV_WAIT_EN
      check("dev_stall", 32'(u_if.stall), 32'd1);
      check("dev_in_en0", 32'(u_if.bus_in_en), 32'd0);
      check("dev_out_en", 32'(u_if.bus_out_en), 32'h40);
      tick();
      tick();
      check("dev_stall3", 32'(u_if.stall), 32'd1);
      check("dev_frozen", 32'(u_if.uaddr[2:0]), 32'd1);
      u_if.dev_rdy = 1'b1;
      #1;
      check("dev_commit_in", 32'(u_if.bus_in_en), 32'h20);
      check("dev_commit_stall", 32'(u_if.stall), 32'd0);
      tick();
      check("dev_advance", 32'(u_if.uaddr[2:0]), 32'd2);
`else
      check("nowait_stall", 32'(u_if.stall), 32'd0);
      check("nowait_in_en", 32'(u_if.bus_in_en), 32'h20);
      tick();
      check("nowait_advance", 32'(u_if.uaddr[2:0]), 32'd2);
`endif

      // Reset taken while (possibly) stalled.
      reset        = 1'b1;
      u_if.uinstr  = 16'h6140;
      u_if.dev_rdy = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("rst_stall", 32'(u_if.stall), 32'd0);
      check("rst_stall_out", 32'(u_if.bus_out_en), 32'd0);
      check("rst_stall_t", 32'(u_if.uaddr[2:0]), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         reset        = ($urandom_range(99) < 2);
         u_if.opcode  = 8'($urandom);
         u_if.uinstr  = 16'($urandom);
         u_if.dev_rdy = ($urandom_range(9) < 6);
         tick();
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
